rf_multiport: RTL and testbench

- Parametrised integer register file for the npc core.
- Supports NRD combinational read ports, NWR synchronous write ports and optional write-to-read bypass.
- Holds a per-register pending-write scoreboard, so the decode stage can detect RAW hazards on in-flight producers.
- Sits between decode (read, issue) and writeback (write, scoreboard clear).

---
 rtl/rf_multiport_if.sv | 30 +++
 rtl/rf_multiport.sv | 89 ++++++++
 tb/tb_rf_multiport.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_multiport_if.sv
// Decode/writeback side of the npc integer register file: read ports, write ports
// and the issue strobe that marks a destination register as having a producer in flight.
interface rf_multiport_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                busy_any;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/rf_multiport.sv
// Multiport integer register file with optional write-to-read bypass and a
// per-register pending-write scoreboard for RAW hazard detection at decode.
module rf_multiport #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  rf_multiport_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NWR-1:0]   wr_live;
  logic             iss_live;
  logic [XLEN-1:0]  rd_d [NRD];
  logic [NRD-1:0]   rd_b;

  // A write is live unless it targets the hardwired zero register.
  always_comb begin
    wr_live = '0;
    for (int w = 0; w < NWR; w++)
      wr_live[w] = bus.wr_en[w] && !(ZERO_REG && bus.wr_addr[w*AW +: AW] == '0);
    iss_live = bus.iss_en && !(ZERO_REG && bus.iss_addr == '0);
  end

  // NOTE: the register array is reset deliberately: every architectural register
  // must read zero straight out of reset, so this storage cannot be an unresettable RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      // NOTE: non-blocking updates in ascending port order, so the last (highest)
      // port targeting an address is the one that lands.
      for (int w = 0; w < NWR; w++)
        if (wr_live[w])
          regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
    end
  end

  // Writebacks clear first, then the issue sets: a newer producer outranks a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++)
      if (wr_live[w])
        busy_nxt[bus.wr_addr[w*AW +: AW]] = 1'b0;
    if (iss_live)
      busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_d[r] = regs[bus.rd_addr[r*AW +: AW]];
      rd_b[r] = busy[bus.rd_addr[r*AW +: AW]];
      if (BYPASS) begin
        for (int w = 0; w < NWR; w++)
          if (wr_live[w] && bus.wr_addr[w*AW +: AW] == bus.rd_addr[r*AW +: AW]) begin
            rd_d[r] = bus.wr_data[w*XLEN +: XLEN];
            rd_b[r] = 1'b0;
          end
      end
      if (ZERO_REG && bus.rd_addr[r*AW +: AW] == '0) begin
        rd_d[r] = '0;
        rd_b[r] = 1'b0;
      end
      // Bypass would otherwise leak write data through while reset is held.
      if (rst)
        rd_d[r] = '0;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign bus.rd_data[r*XLEN +: XLEN] = rd_d[r];
  end
  assign bus.rd_busy  = rd_b;
  assign bus.busy_any = |busy;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed scoreboard bench: u_a has bypass and two write ports, u_b has neither,
// both see the same read/issue/port-0 stimulus.
module tb_rf_multiport;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_multiport_if #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(2)) if_a ();
  rf_multiport_if #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(1)) if_b ();

  rf_multiport #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  rf_multiport #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(1'b0), .ZERO_REG(1'b1))
    u_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct {
    string           name;
    int              dut;
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            any;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: drains every queued expectation whenever a sample point is announced.
  initial begin
    exp_t            e;
    logic [XLEN-1:0] d;
    logic            b, a;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut == 0) begin
          d = if_a.rd_data[e.port*XLEN +: XLEN];
          b = if_a.rd_busy[e.port];
          a = if_a.busy_any;
        end else begin
          d = if_b.rd_data[e.port*XLEN +: XLEN];
          b = if_b.rd_busy[e.port];
          a = if_b.busy_any;
        end
        check({e.name, ".data"}, d, e.data);
        check({e.name, ".busy"}, {63'd0, b}, {63'd0, e.busy});
        check({e.name, ".any"},  {63'd0, a}, {63'd0, e.any});
      end
    end
  end

  task automatic expect_rd(input string nm, input int dut, input int port,
                           input logic [XLEN-1:0] d, input logic b, input logic any);
    exp_t e;
    e.name = nm; e.dut = dut; e.port = port; e.data = d; e.busy = b; e.any = any;
    sb.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
  endtask

  task automatic idle();
    if_a.wr_en = '0; if_a.iss_en = 1'b0;
    if_b.wr_en = '0; if_b.iss_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input int addr);
    logic [AW-1:0] a5;
    a5 = AW'(addr);
    if_a.rd_addr[p*AW +: AW] = a5;
    if_b.rd_addr[p*AW +: AW] = a5;
  endtask

  // Port 0 drives both instances; port 1 exists only on u_a.
  task automatic drive_wr(input int w, input int addr, input logic [XLEN-1:0] data);
    logic [AW-1:0] a5;
    a5 = AW'(addr);
    if_a.wr_en[w] = 1'b1;
    if_a.wr_addr[w*AW +: AW] = a5;
    if_a.wr_data[w*XLEN +: XLEN] = data;
    if (w == 0) begin
      if_b.wr_en[0] = 1'b1;
      if_b.wr_addr[AW-1:0] = a5;
      if_b.wr_data[XLEN-1:0] = data;
    end
  endtask

  task automatic issue(input int addr);
    if_a.iss_en = 1'b1; if_a.iss_addr = AW'(addr);
    if_b.iss_en = 1'b1; if_b.iss_addr = AW'(addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    if_a.wr_en = '0; if_a.wr_addr = '0; if_a.wr_data = '0; if_a.iss_en = 1'b0; if_a.iss_addr = '0;
    if_b.wr_en = '0; if_b.wr_addr = '0; if_b.wr_data = '0; if_b.iss_en = 1'b0; if_b.iss_addr = '0;
    if_a.rd_addr = '0; if_b.rd_addr = '0;

    // Reset then read
    #2;
    set_rd(0, 5); set_rd(1, 31);
    for (int d = 0; d < 2; d++) begin
      expect_rd("rst_rd5", d, 0, '0, 1'b0, 1'b0);
      expect_rd("rst_rd31", d, 1, '0, 1'b0, 1'b0);
    end
    sample();
    @(negedge clk); rst = 1'b0;
    sample();
    for (int d = 0; d < 2; d++) expect_rd("post_rst_rd5", d, 0, '0, 1'b0, 1'b0);
    -> sample_ev;

    // Write / readback, bypass vs stored
    @(negedge clk); drive_wr(0, 3, 64'hDEADBEEF_00000001); set_rd(0, 3);
    #1;
    expect_rd("wr3_byp", 0, 0, 64'hDEADBEEF_00000001, 1'b0, 1'b0);
    expect_rd("wr3_nobyp", 1, 0, '0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk); idle();
    #1;
    for (int d = 0; d < 2; d++) expect_rd("wr3_stored", d, 0, 64'hDEADBEEF_00000001, 1'b0, 1'b0);
    -> sample_ev;

    // Zero register: write and issue both dropped
    @(negedge clk); drive_wr(0, 0, 64'hFFFF); issue(0); set_rd(0, 0);
    #1;
    for (int d = 0; d < 2; d++) expect_rd("zero_same", d, 0, '0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk); idle();
    #1;
    for (int d = 0; d < 2; d++) expect_rd("zero_next", d, 0, '0, 1'b0, 1'b0);
    -> sample_ev;

    // Scoreboard on register 7
    @(negedge clk); issue(7); set_rd(1, 7);
    #1;
    for (int d = 0; d < 2; d++) expect_rd("iss7_same", d, 1, '0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk); issue(7); drive_wr(0, 7, 64'h77);
    #1;
    expect_rd("iss_wr7_byp", 0, 1, 64'h77, 1'b0, 1'b1);
    expect_rd("iss_wr7_nobyp", 1, 1, '0, 1'b1, 1'b1);
    -> sample_ev;
    @(negedge clk); idle(); drive_wr(0, 7, 64'h7777);
    #1;
    expect_rd("wr7_byp", 0, 1, 64'h7777, 1'b0, 1'b1);
    expect_rd("wr7_nobyp", 1, 1, 64'h77, 1'b1, 1'b1);
    -> sample_ev;
    @(negedge clk); idle();
    #1;
    for (int d = 0; d < 2; d++) expect_rd("wr7_retired", d, 1, 64'h7777, 1'b0, 1'b0);
    -> sample_ev;

    // Dual-port conflict on register 9 (u_a only has port 1)
    @(negedge clk); drive_wr(0, 9, 64'h11); drive_wr(1, 9, 64'h22); set_rd(0, 9);
    #1;
    expect_rd("conf9_byp", 0, 0, 64'h22, 1'b0, 1'b0);
    expect_rd("conf9_nobyp", 1, 0, '0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk); idle();
    #1;
    expect_rd("conf9_stored_a", 0, 0, 64'h22, 1'b0, 1'b0);
    expect_rd("conf9_stored_b", 1, 0, 64'h11, 1'b0, 1'b0);
    -> sample_ev;

    // Async reset mid-operation
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle(); drive_wr(0, i, 64'h100 + 64'(i));
    end
    @(negedge clk); idle(); issue(4);
    @(negedge clk); idle(); set_rd(0, 4); set_rd(1, 1);
    #1;
    for (int d = 0; d < 2; d++) begin
      expect_rd("pre_rst_r4", d, 0, 64'h104, 1'b1, 1'b1);
      expect_rd("pre_rst_r1", d, 1, 64'h101, 1'b0, 1'b1);
    end
    -> sample_ev;
    #1; rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      expect_rd("mid_rst_r4", d, 0, '0, 1'b0, 1'b0);
      expect_rd("mid_rst_r1", d, 1, '0, 1'b0, 1'b0);
    end
    -> sample_ev;
    #1; rst = 1'b0;
    @(negedge clk); drive_wr(0, 4, 64'hABC);
    #1;
    expect_rd("post_rst_wr4_byp", 0, 0, 64'hABC, 1'b0, 1'b0);
    expect_rd("post_rst_wr4_nobyp", 1, 0, '0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) expect_rd("post_rst_r1", d, 1, '0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk); idle();
    #1;
    for (int d = 0; d < 2; d++) expect_rd("post_rst_r4_stored", d, 0, 64'hABC, 1'b0, 1'b0);
    -> sample_ev;

    #1;
    check("sb_drained", 64'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
